// File: rtl/pio_pkg.sv
// Shared definitions for the PIO blocks: register addresses, edge-type encodings
// and the start-up guard state type.
package pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

   localparam int PIO_EDGE_RISE = 0;
   localparam int PIO_EDGE_FALL = 1;
   localparam int PIO_EDGE_ANY  = 2;

   typedef enum logic [1:0] {
      GUARD_ARM0 = 2'd0,
      GUARD_ARM1 = 2'd1,
      GUARD_ARM2 = 2'd2,
      GUARD_RUN  = 2'd3
   } guard_state_e;

   function automatic guard_state_e guard_next(input guard_state_e cur);
      guard_state_e nxt;
      case (cur)
         GUARD_ARM0: nxt = GUARD_ARM1;
         GUARD_ARM1: nxt = GUARD_ARM2;
         GUARD_ARM2: nxt = GUARD_RUN;
         GUARD_RUN:  nxt = GUARD_RUN;
         default:    nxt = GUARD_ARM0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One-bit debouncer: the output follows the input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module pio_in_debounce
   import pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic lvl
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_r;
   logic          lvl_r;

   // Stability counter; any agreement between input and output restarts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
         lvl_r <= 1'b0;
      end else if (din == lvl_r) begin
         cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= {CW{1'b0}};
         lvl_r <= din;
      end else begin
         cnt_r <= cnt_r + CW'(1'b1);
      end
   end

   assign lvl = lvl_r;

endmodule

// File: rtl/system_0_pio_button_in.sv
// Avalon-MM input PIO with per-bit edge capture and masked level interrupt.
// Optional per-bit debouncing is enabled by defining PIO_IN_DEBOUNCE_EN.
module system_0_pio_button_in
   import pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("system_0_pio_button_in: WIDTH must be 1..32");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("system_0_pio_button_in: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] lvl_s;
   logic [WIDTH-1:0] lvl_prev_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic [WIDTH-1:0] edge_capture_r;
   logic [WIDTH-1:0] edge_det_s;
   logic [WIDTH-1:0] mask_nxt_s;
   logic [WIDTH-1:0] edge_nxt_s;
   logic             irq_r;
   logic             write_s;
   logic             unused_wdata_s;
   guard_state_e     state_r;

   assign write_s        = chipselect & ~write_n;
   assign unused_wdata_s = ^writedata;

   // Pin synchronizer and previous conditioned level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r    <= {WIDTH{1'b0}};
         sync2_r    <= {WIDTH{1'b0}};
         lvl_prev_r <= {WIDTH{1'b0}};
      end else begin
         sync1_r    <= in_port;
         sync2_r    <= sync1_r;
         lvl_prev_r <= lvl_s;
      end
   end

`ifdef PIO_IN_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      pio_in_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .din   (sync2_r[i]),
         .lvl   (lvl_s[i])
      );
   end
`else
   assign lvl_s = sync2_r;
`endif

   // Start-up guard: pins already high at reset release must not look like edges
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= GUARD_ARM0;
      end else begin
         state_r <= guard_next(state_r);
      end
   end

   // Per-bit edge detect, suppressed until the guard reaches RUN
   always_comb begin
      edge_det_s = {WIDTH{1'b0}};
      if (state_r == GUARD_RUN) begin
         case (EDGE_TYPE)
            PIO_EDGE_RISE: edge_det_s = lvl_s & ~lvl_prev_r;
            PIO_EDGE_FALL: edge_det_s = ~lvl_s & lvl_prev_r;
            PIO_EDGE_ANY:  edge_det_s = lvl_s ^ lvl_prev_r;
            default:       edge_det_s = {WIDTH{1'b0}};
         endcase
      end else begin
         edge_det_s = {WIDTH{1'b0}};
      end
   end

   // Next mask / capture values; a new edge is OR-ed in after the W1C so it is never lost
   always_comb begin
      mask_nxt_s = irq_mask_r;
      edge_nxt_s = edge_capture_r;
      if (write_s && (address == PIO_ADDR_MASK)) begin
         mask_nxt_s = writedata[WIDTH-1:0];
      end else begin
         mask_nxt_s = irq_mask_r;
      end
      if (write_s && (address == PIO_ADDR_EDGE)) begin
         edge_nxt_s = edge_capture_r & ~writedata[WIDTH-1:0];
      end else begin
         edge_nxt_s = edge_capture_r;
      end
      edge_nxt_s = edge_nxt_s | edge_det_s;
   end

   // Control registers; irq is registered from the same next values so it tracks them exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask_r     <= {WIDTH{1'b0}};
         edge_capture_r <= {WIDTH{1'b0}};
         irq_r          <= 1'b0;
      end else begin
         irq_mask_r     <= mask_nxt_s;
         edge_capture_r <= edge_nxt_s;
         irq_r          <= |(edge_nxt_s & mask_nxt_s);
      end
   end

   // Zero-wait-state read mux
   always_comb begin
      readdata = 32'd0;
      case (address)
         PIO_ADDR_DATA: readdata[WIDTH-1:0] = lvl_s;
         PIO_ADDR_MASK: readdata[WIDTH-1:0] = irq_mask_r;
         PIO_ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture_r;
         default:       readdata = 32'd0;
      endcase
   end

   assign irq = irq_r;

endmodule

// File: tb/tb_system_0_pio_button_in.sv
// Directed bench for system_0_pio_button_in with a queue scoreboard of expected observations.
`timescale 1ns/1ps
module tb_system_0_pio_button_in;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;
   logic [31:0] readdata_any;
   logic        irq_any;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   always #10 clk = ~clk;

   system_0_pio_button_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   system_0_pio_button_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) dut_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata_any), .irq(irq_any)
   );

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=%h expected=<queued entry>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic obs_reg(input logic [1:0] a);
      address = a;
      #1;
      pop_cmp(readdata);
   endtask

   task automatic obs_any(input logic [1:0] a);
      address = a;
      #1;
      pop_cmp(readdata_any);
   endtask

   task automatic obs_irq();
      #1;
      pop_cmp({31'd0, irq});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] v);
      @(negedge clk);
      in_port = v;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_RSVD = 2'd1;
   localparam logic [1:0] A_MASK = 2'd2;
   localparam logic [1:0] A_EDGE = 2'd3;

   initial begin
      reset      = 1'b1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = A_DATA;
      writedata  = 32'd0;
`ifndef PIO_IN_DEBOUNCE_EN
      // pins high through reset
      in_port = 4'hF;
      #25;
      push("rst_data", 32'h0); obs_reg(A_DATA);
      push("rst_irq", 32'h0);  obs_irq();
      @(negedge clk);
      reset = 1'b0;
      push("boot_data_e1", 32'h0); tick(1); obs_reg(A_DATA);
      push("boot_data_e2", 32'hF); tick(1); obs_reg(A_DATA);
      tick(3);
      push("boot_edge", 32'h0);     obs_reg(A_EDGE);
      push("boot_irq", 32'h0);      obs_irq();
      push("boot_edge_any", 32'h0); obs_any(A_EDGE);

      // falling edges: ignored by rise instance, captured by any-edge instance
      set_in(4'h0);
      tick(3);
      push("fall_edge_any", 32'hF);  obs_any(A_EDGE);
      push("fall_edge_rise", 32'h0); obs_reg(A_EDGE);
      wr(A_MASK, 32'h1);
      wr(A_EDGE, 32'hF);
      push("clr_all", 32'h0); obs_reg(A_EDGE);

      // rise on bit0 with mask bit0: capture and irq on 3rd edge
      set_in(4'h1);
      push("t2_edge_e1", 32'h0);
      push("t2_data_e2", 32'h1);
      push("t2_edge_e2", 32'h0);
      push("t2_irq_e2", 32'h0);
      push("t2_edge_e3", 32'h1);
      push("t2_irq_e3", 32'h1);
      tick(1); obs_reg(A_EDGE);
      tick(1); obs_reg(A_DATA); obs_reg(A_EDGE); obs_irq();
      tick(1); obs_reg(A_EDGE); obs_irq();
      wr(A_EDGE, 32'h1);
      push("t2_w1c_edge", 32'h0); obs_reg(A_EDGE);
      push("t2_w1c_irq", 32'h0);  obs_irq();

      // read-only and reserved locations ignore writes
      wr(A_RSVD, 32'hFFFF_FFFF);
      wr(A_DATA, 32'h0);
      push("rsvd_read", 32'h0); obs_reg(A_RSVD);
      push("data_ro", 32'h1);   obs_reg(A_DATA);
      wr(A_MASK, 32'hA5A5_A5A2);
      push("mask_upper", 32'h2); obs_reg(A_MASK);
      wr(A_MASK, 32'h0);

      // masked capture, then unmask
      set_in(4'h5);
      tick(3);
      push("t3_edge", 32'h4); obs_reg(A_EDGE);
      push("t3_irq0", 32'h0); obs_irq();
      wr(A_MASK, 32'h4);
      push("t3_irq1", 32'h1); obs_irq();

      // W1C coincident with a new edge on the same bit
      wr(A_EDGE, 32'hF);
      set_in(4'h4);
      tick(3);
      push("t4_any_fall", 32'h1);  obs_any(A_EDGE);
      push("t4_rise_none", 32'h0); obs_reg(A_EDGE);
      wr(A_EDGE, 32'hF);
      set_in(4'h5);
      tick(2);
      wr(A_EDGE, 32'h1);
      push("t4_set_wins", 32'h1);     obs_reg(A_EDGE);
      push("t4_irq_masked", 32'h0);   obs_irq();
      push("t4_set_wins_any", 32'h1); obs_any(A_EDGE);

      // async reset mid-operation
      wr(A_MASK, 32'hF);
      push("t5_irq_pre", 32'h1); obs_irq();
      set_in(4'h7);
      tick(3);
      push("t5_edge_pre", 32'h3); obs_reg(A_EDGE);
      push("t5_irq_pre2", 32'h1); obs_irq();
      @(posedge clk);
      #3;
      reset = 1'b1;
      push("t5_irq_rst", 32'h0);  obs_irq();
      push("t5_edge_rst", 32'h0); obs_reg(A_EDGE);
      push("t5_mask_rst", 32'h0); obs_reg(A_MASK);
      push("t5_data_rst", 32'h0); obs_reg(A_DATA);
      @(negedge clk);
      reset = 1'b0;
      tick(5);
      push("t5_data_post", 32'h7); obs_reg(A_DATA);
      push("t5_edge_post", 32'h0); obs_reg(A_EDGE);
`else
      in_port = 4'h0;
      #25;
      push("rst_data", 32'h0); obs_reg(A_DATA);
      push("rst_irq", 32'h0);  obs_irq();
      @(negedge clk);
      reset = 1'b0;
      tick(4);
      wr(A_MASK, 32'h1);

      // 3-clock glitch is filtered
      set_in(4'h1);
      tick(3);
      set_in(4'h0);
      tick(20);
      push("db_glitch_data", 32'h0); obs_reg(A_DATA);
      push("db_glitch_edge", 32'h0); obs_reg(A_EDGE);

      // 10-clock pulse passes after 8 stable clocks behind sync2
      set_in(4'h1);
      push("db_data_e9", 32'h0);
      push("db_data_e10", 32'h1);
      push("db_edge_e11", 32'h1);
      push("db_irq_e11", 32'h1);
      tick(9); obs_reg(A_DATA);
      tick(1); obs_reg(A_DATA);
      set_in(4'h0);
      tick(1); obs_reg(A_EDGE); obs_irq();
      tick(20);
      push("db_data_low", 32'h0); obs_reg(A_DATA);
      push("db_one_edge", 32'h1); obs_reg(A_EDGE);
`endif
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
